// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits MSB first, optional even
// parity, stop bit; the received word is held on a one-entry valid/ready output.
module serial_frame_rx #(
   parameter int unsigned DATA_W    = 8,
   parameter bit          PARITY_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              serial_in,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);

   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // state is left as a named register so assertions can bind to it directly
   state_t            state;
   logic [DATA_W-1:0] shift_q;
   logic [CNT_W-1:0]  bit_cnt;
   logic              par_err_q;

   // Handshake: a word transfers on any edge where data_valid & out_ready;
   // data_out/parity_err hold while data_valid=1 and out_ready=0, and a new
   // word may load on the same edge the held one is consumed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         shift_q    <= '0;
         bit_cnt    <= '0;
         par_err_q  <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         if (data_valid && out_ready) begin
            data_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!serial_in) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  busy    <= 1'b1;
               end
            end
            DATA: begin
               shift_q <= {shift_q[DATA_W-2:0], serial_in};
               if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= '0;
                  state   <= PARITY_EN ? PARITY : STOP;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            PARITY: begin
               par_err_q <= ^{shift_q, serial_in};
               state     <= STOP;
            end
            STOP: begin
               // a low stop bit is reported, never reused as the next start bit
               state <= IDLE;
               busy  <= 1'b0;
               if (serial_in) begin
                  if (!data_valid || out_ready) begin
                     data_out   <= shift_q;
                     parity_err <= par_err_q;
                     data_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end else begin
                  frame_err <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames plus random frames for parity and
// no-parity builds, checked every cycle against a frame-level reference model.
module tb_serial_frame_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       out_ready;
   logic       sin_p, sin_n;
   logic [7:0] dout_p, dout_n;
   logic       dv_p, pe_p, fe_p, ov_p, bz_p;
   logic       dv_n, pe_n, fe_n, ov_n, bz_n;

   serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) dut_p (
      .clk(clk), .rst(rst), .serial_in(sin_p), .out_ready(out_ready),
      .data_out(dout_p), .data_valid(dv_p), .parity_err(pe_p),
      .frame_err(fe_p), .overrun(ov_p), .busy(bz_p)
   );

   serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b0)) dut_n (
      .clk(clk), .rst(rst), .serial_in(sin_n), .out_ready(out_ready),
      .data_out(dout_n), .data_valid(dv_n), .parity_err(pe_n),
      .frame_err(fe_n), .overrun(ov_n), .busy(bz_n)
   );

   // clock / reset
   always #5 clk = ~clk;

   bit         use_n = 1'b0;
   logic [7:0] obs_dout;
   logic       obs_dv, obs_pe, obs_fe, obs_ov, obs_bz;

   always_comb begin
      obs_dout = use_n ? dout_n : dout_p;
      obs_dv   = use_n ? dv_n   : dv_p;
      obs_pe   = use_n ? pe_n   : pe_p;
      obs_fe   = use_n ? fe_n   : fe_p;
      obs_ov   = use_n ? ov_n   : ov_p;
      obs_bz   = use_n ? bz_n   : bz_p;
   end

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, no_parity=%0d)", tag, got, exp, cyc, use_n);
      end
   endtask

   // reference model: output-register occupancy and per-edge pulses
   logic [7:0] m_data;
   bit         m_valid, m_perr, m_ferr, m_ovr, m_busy;
   bit         prev_dv;
   int         rise_q[$];

   task automatic model_reset();
      m_data = 8'h00; m_valid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0; m_busy = 0;
      prev_dv = 0;
   endtask

   // one clock: present inputs, let the edge happen, predict, then compare
   task automatic step(input logic b, input logic rdy, input bit is_stop, input bit busy_after,
                       input logic [7:0] w, input bit perr);
      bit was_valid;
      if (use_n) sin_n = b; else sin_p = b;
      out_ready = rdy;
      @(posedge clk);
      cyc++;
      was_valid = m_valid;
      m_ferr = 0;
      m_ovr  = 0;
      if (m_valid && rdy) m_valid = 0;
      if (is_stop) begin
         if (b) begin
            if (!was_valid || rdy) begin
               m_valid = 1; m_data = w; m_perr = perr;
            end else begin
               m_ovr = 1;
            end
         end else begin
            m_ferr = 1;
         end
      end
      m_busy = busy_after;
      @(negedge clk);
      check("data_valid", 32'(obs_dv), 32'(m_valid));
      check("frame_err",  32'(obs_fe), 32'(m_ferr));
      check("overrun",    32'(obs_ov), 32'(m_ovr));
      check("busy",       32'(obs_bz), 32'(m_busy));
      if (m_valid) begin
         check("data_out",   32'(obs_dout), 32'(m_data));
         check("parity_err", 32'(obs_pe),   32'(m_perr));
      end
      if (obs_dv && !prev_dv) rise_q.push_back(cyc);
      prev_dv = obs_dv;
   endtask

   function automatic logic pick_rdy(input int mode, input int k, input int s);
      case (mode)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return 1'($urandom_range(0, 1));
         default: return (k == s) ? 1'b1 : 1'b0;
      endcase
   endfunction

   // driver: mode 0 ready low, 1 ready high, 2 random, 3 ready only on the stop cycle
   task automatic send_frame(input logic [7:0] w, input logic pbit, input logic stop, input int mode);
      int s;
      bit perr;
      s    = use_n ? 9 : 10;
      perr = use_n ? 1'b0 : 1'(($countones(w) + 32'(pbit)) % 2);
      step(1'b0, pick_rdy(mode, 0, s), 0, 1, 8'h00, 0);
      for (int i = 0; i < 8; i++) step(w[7-i], pick_rdy(mode, i + 1, s), 0, 1, 8'h00, 0);
      if (!use_n) step(pbit, pick_rdy(mode, 9, s), 0, 1, 8'h00, 0);
      step(stop, pick_rdy(mode, s, s), 1, 0, w, perr);
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) step(1'b1, rdy, 0, 0, 8'h00, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"},  32'(obs_dout), 32'h0);
      check({tag, "_valid"}, 32'(obs_dv),   32'h0);
      check({tag, "_perr"},  32'(obs_pe),   32'h0);
      check({tag, "_ferr"},  32'(obs_fe),   32'h0);
      check({tag, "_ovr"},   32'(obs_ov),   32'h0);
      check({tag, "_busy"},  32'(obs_bz),   32'h0);
   endtask

   task automatic do_reset();
      rst = 1'b0; sin_p = 1'b1; sin_n = 1'b1; out_ready = 1'b0;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic b2b_spacing(input int s);
      rise_q.delete();
      send_frame(8'h00, 1'b0, 1'b1, 1);
      send_frame(8'hFF, 1'b0, 1'b1, 1);
      send_frame(8'h5A, 1'b0, 1'b1, 1);
      idle(2, 1'b1);
      check("b2b_words", 32'(rise_q.size()), 32'd3);
      if (rise_q.size() == 3) begin
         check("b2b_gap1", 32'(rise_q[1] - rise_q[0]), 32'(s + 1));
         check("b2b_gap2", 32'(rise_q[2] - rise_q[1]), 32'(s + 1));
      end
   endtask

   task automatic random_frames(input int n);
      for (int i = 0; i < n; i++) begin
         send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) != 0), 2);
         idle($urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
      idle(2, 1'b1);
   endtask

   initial begin
      model_reset();
      do_reset();
      idle(2, 1'b0);

      // parity build
      send_frame(8'hA5, 1'b0, 1'b1, 1);
      idle(2, 1'b1);
      send_frame(8'hA5, 1'b1, 1'b1, 0);
      idle(1, 1'b1);
      send_frame(8'h77, 1'b1, 1'b0, 1);
      send_frame(8'h3C, 1'b0, 1'b1, 1);
      idle(2, 1'b1);

      send_frame(8'h11, 1'b0, 1'b1, 0);
      send_frame(8'h22, 1'b0, 1'b1, 0);
      idle(2, 1'b1);
      send_frame(8'h11, 1'b0, 1'b1, 0);
      send_frame(8'h22, 1'b0, 1'b1, 3);
      idle(2, 1'b1);

      b2b_spacing(10);

      // reset during data bit 4 while a word is still held
      send_frame(8'h96, 1'b0, 1'b1, 0);
      step(1'b0, 1'b0, 0, 1, 8'h00, 0);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 1, 8'h00, 0);
      rst = 1'b0;
      #1;
      check_reset_outputs("midreset");
      @(negedge clk);
      sin_p = 1'b1;
      rst = 1'b1;
      model_reset();
      idle(2, 1'b0);
      send_frame(8'h81, 1'b0, 1'b1, 1);
      idle(2, 1'b1);

      random_frames(40);

      // no-parity build
      use_n = 1'b1;
      do_reset();
      idle(2, 1'b0);
      b2b_spacing(9);
      send_frame(8'hC3, 1'b0, 1'b0, 1);
      send_frame(8'h3C, 1'b0, 1'b1, 1);
      idle(2, 1'b1);
      random_frames(40);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial frame receiver that consumes the one-bit-per-clock stream from the SISO shift-register stage, MSB first. It detects start and stop framing, shifts in a data word, checks optional even parity, and presents the word on a registered parallel output with a valid/ready handshake. It sits directly downstream of the SISO register and converts its serial output back into words for the parallel datapath.

## Interface
- DATA_W, 8: data bits per frame, legal range 2–32.
- PARITY_EN, 1: 1 means the frame carries an even-parity bit after the data; 0 means no parity bit.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- serial_in  in  1  serial stream, driven by the SISO stage's serial_out; idle level 1.
- out_ready  in  1  downstream can accept data_out this cycle.
- data_out  out  DATA_W  received word; the first received bit lands in the MSB.
- data_valid  out  1  data_out holds an unconsumed word.
- parity_err  out  1  qualifier of the held word: parity mismatch. Valid only while data_valid=1.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun  out  1  one-cycle pulse: a good frame was dropped because the output was occupied.
- busy  out  1  1 whenever the FSM is not in IDLE.

## Operation
- Frame format, one bit per clk:
  - start bit 0;
  - DATA_W data bits, MSB first;
  - parity bit, only if PARITY_EN=1 (even parity: XOR of data and parity bits = 0);
  - stop bit 1.
- FSM states are IDLE, DATA, PARITY and STOP.
  - IDLE → DATA when serial_in=0 is sampled.
  - DATA shifts serial_in into the LSB of the internal shift register (shift left). It uses a bit counter 0..DATA_W-1 and leaves after DATA_W samples: to PARITY if PARITY_EN=1, else to STOP.
  - PARITY samples one bit, latches the mismatch, then goes to STOP.
  - STOP samples one bit, then goes to IDLE unconditionally.
- Stop bit = 1 (good frame):
  - If the output is free, or is being consumed this cycle (data_valid & out_ready), load data_out and parity_err, and set data_valid.
  - Otherwise pulse overrun, drop the new word, and leave the held word untouched.
- Stop bit = 0: pulse frame_err and discard the word. No output register change. That 0 is not treated as a new start bit.
- Handshake:
  - A transfer occurs when data_valid & out_ready; data_valid falls the next cycle unless a new word loads that same edge.
  - data_out and parity_err are stable while data_valid=1 and out_ready=0.
  - out_ready has no effect when data_valid=0.
- Reset values (asynchronous):
  - FSM in IDLE, shift register and counter 0.
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
- Reset mid-frame aborts the frame with no error pulse. Reception resumes with the first 0 sampled after rst deasserts.

## Timing
- Let cycle 0 be the edge where the start bit is sampled in IDLE.
  - Data bits are sampled at cycles 1..DATA_W.
  - The parity bit is sampled at cycle DATA_W+1 (PARITY_EN=1).
  - The stop bit is sampled at cycle S = DATA_W+1+PARITY_EN.
- data_valid, frame_err and overrun are registered and visible after edge S. For DATA_W=8, PARITY_EN=1, S=10.
- busy is high from after edge 0 through edge S; it reads 0 after edge S.
- Back-to-back frames: a start bit on the cycle immediately after the stop bit is accepted. The sustained rate is one word per S+1 cycles, with no dead cycles.
- The output stage holds one word. Throughput is unaffected as long as out_ready is asserted at least once per S+1 cycles.

## Test plan
- Single frame, DATA_W=8, PARITY_EN=1, word 0xA5, parity bit 0, stop 1, out_ready=1 → data_out=0xA5, data_valid=1 after edge 10 for one cycle, parity_err=0, busy low after edge 10.
- Same frame with parity bit 1 → data_out=0xA5, data_valid=1, parity_err=1; frame_err=0.
- Stop bit 0 → frame_err pulses one cycle after edge 10; data_valid stays 0. A following 0x3C frame sent one cycle later is received correctly.
- Backpressure: out_ready=0, send 0x11 then 0x22 back-to-back → data_out stays 0x11 and overrun pulses at the second stop. Raise out_ready on the second frame's stop cycle instead → 0x22 loads, no overrun.
- Back-to-back 0x00, 0xFF, 0x5A with out_ready=1 → three valid words 11 cycles apart, no errors; then PARITY_EN=0 → spacing 10 cycles.
- rst pulled low at data bit 4 of a frame → all outputs 0 immediately; after release, the next 0x81 frame is received correctly with no spurious error pulse.
